yamin_dcu_tag_arb: RTL and testbench
====================================

Name: yamin_dcu_tag_arb

Overview:
Arbiter and pipeline sequencer for the single-ported D-cache tag RAM inside yamin_dcu. It selects one of six requesters per cycle in M0 (BIU alloc, BIU evict, ECC maintenance, LSU load, STB, BIU prefetch lookup) and drives the tag RAM enable and write strobe. It returns M1 acks and tracks the winner's source ID through M1–M3 so downstream hit/ECC logic can steer results. Starvation of the STB and prefetch requesters is bounded by aging counters.

Parameters:
STARVE_MAX, 7, consecutive denied cycles before STB/PF are promoted (counter width clog2(STARVE_MAX+1))
NUM_WAYS, 4, tag RAM ways (one-hot way vectors)

Ports:
clk  in  1  core clock
csysreset_n  in  1  asynchronous active-low reset
req_m0_i  in  6  request per source: [0]ALLOC [1]EV [2]MAINT [3]LD [4]STB [5]PF
wr_m0_i  in  6  per-source write intent; ignored for LD, PF
way_m0_i  in  6*NUM_WAYS  per-source one-hot way select
ecc_lock_i  in  1  ECC FSM busy: only MAINT eligible
mbist_active_i  in  1  MBIST owns RAM: no grants
stb_force_i  in  1  STB drain: STB promoted to just below ALLOC
has_priority_m0_o  out  6  one-hot combinational grant
ack_m1_o  out  6  registered grant
ram_tag_en_o  out  NUM_WAYS  tag RAM way enables (M0)
ram_tag_wr_o  out  1  tag RAM write (M0)
src_vld_m1_o/m2_o/m3_o  out  1 each  pipeline valid
src_id_m1_o/m2_o/m3_o  out  3 each  winning source index
ld_stall_m0_o  out  1  LD requested and not granted

Behaviour:
- Reset: all outputs 0; pipeline valids 0; aging counters 0. Reset mid-transaction drops in-flight entries; no ack is issued after reset release for pre-reset requests.
- Base priority: ALLOC > EV > MAINT > LD > STB > PF.
- Aging: STB and PF counters each increment when req is set and not granted, saturating at STARVE_MAX. A counter clears when its source is granted or its req drops. At STARVE_MAX the source is promoted above LD and stays below MAINT. If both are promoted, STB wins.
- stb_force_i=1: STB ranks directly after ALLOC, above EV.
- ecc_lock_i=1: only MAINT can win; other requests are denied and aging still counts.
- mbist_active_i=1: has_priority=0, ram_tag_en=0, and aging is frozen. Takes precedence over ecc_lock_i.
- has_priority_m0_o is one-hot or zero.
- ram_tag_en_o = way_m0_i of the winner. A read with all-zero way enables all ways.
- ram_tag_wr_o = wr_m0_i[winner] & ~(winner in {LD,PF}).
- Latency: grant in cycle N gives ack_m1_o and src_vld_m1 in N+1, src_vld_m2 in N+2, src_vld_m3 in N+3. There are no pipeline stalls: a new winner is accepted every cycle.
- Requesters hold req until has_priority is seen. Deasserting req in the same cycle as the grant is illegal (assertion).
- ld_stall_m0_o = req[LD] & ~has_priority[LD].
- X-check assertions on all outputs outside reset; one-hot assertion on grant.

Decomposition:
- yamin_dcu_pkg gains: the tag_src_e enum (ALLOC..PF, 3 bits), TAG_SRC_NUM=6, and the base priority order constant.
- One sub-module, yamin_dcu_age_ctr, instantiated twice (STB, PF): saturating counter with clear, increment, freeze, and at_max.

Test Plan:
- All six req asserted on the cycle after reset -> grants ALLOC, EV, MAINT, LD, STB, PF in consecutive cycles as each drops. ack_m1 follows one cycle later; src_id_m3 sequence is 0,1,2,3,4,5.
- LD held continuously with STB requesting, STARVE_MAX=7 -> STB is denied for 7 cycles, granted on cycle 8, and its counter returns to 0.
- ecc_lock_i=1 with LD+MAINT requesting -> only MAINT is granted. ld_stall_m0_o=1 until lock drops, then LD is granted the next cycle.
- mbist_active_i=1 for 5 cycles with STB pending and its counter at 3 -> no grants and ram_tag_en=0. The counter stays 3 and resumes counting after release.
- STB write with way 4'b0100, wr=1 -> ram_tag_en=4'b0100 and ram_tag_wr=1. PF with wr=1 gives ram_tag_wr=0 and ram_tag_en=4'b1111.
- Async reset asserted while src_vld_m2=1 -> all valids and acks are 0 immediately, with no residual ack after reset release.

Source files
------------

// File: rtl/yamin_dcu_pkg.sv
// Shared types for the yamin D-cache unit: tag RAM requester IDs and their
// base arbitration order.
package yamin_dcu_pkg;

   localparam int TAG_SRC_NUM = 6;

   typedef enum logic [2:0] {
      SRC_ALLOC = 3'd0,
      SRC_EV    = 3'd1,
      SRC_MAINT = 3'd2,
      SRC_LD    = 3'd3,
      SRC_STB   = 3'd4,
      SRC_PF    = 3'd5
   } tag_src_e;

   // Highest priority first.
   localparam tag_src_e TAG_BASE_PRIO [TAG_SRC_NUM] =
      '{SRC_ALLOC, SRC_EV, SRC_MAINT, SRC_LD, SRC_STB, SRC_PF};

endpackage

// File: rtl/yamin_dcu_age_ctr.sv
// Saturating starvation counter: freeze beats clear, clear beats increment.
// at_max_o flags that the owner has waited long enough to be promoted.
module yamin_dcu_age_ctr #(
   parameter int MAX = 7
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic inc_i,
   input  logic frz_i,
   output logic at_max_o
);

   localparam int W = $clog2(MAX + 1);
   localparam logic [W-1:0] CNT_MAX = W'(MAX);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (frz_i) begin
         cnt_d = cnt_q;
      end else if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_max_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/yamin_dcu_tag_arb.sv
// D-cache tag RAM arbiter: picks one of six requesters in M0, drives the tag
// RAM strobes and carries the winner's ID down the M1..M3 pipeline.
module yamin_dcu_tag_arb
   import yamin_dcu_pkg::*;
#(
   parameter int STARVE_MAX = 7,
   parameter int NUM_WAYS   = 4
) (
   input  logic                            clk,
   input  logic                            csysreset_n,
   input  logic [TAG_SRC_NUM-1:0]          req_m0_i,
   input  logic [TAG_SRC_NUM-1:0]          wr_m0_i,
   input  logic [TAG_SRC_NUM*NUM_WAYS-1:0] way_m0_i,
   input  logic                            ecc_lock_i,
   input  logic                            mbist_active_i,
   input  logic                            stb_force_i,
   output logic [TAG_SRC_NUM-1:0]          has_priority_m0_o,
   output logic [TAG_SRC_NUM-1:0]          ack_m1_o,
   output logic [NUM_WAYS-1:0]             ram_tag_en_o,
   output logic                            ram_tag_wr_o,
   output logic                            src_vld_m1_o,
   output logic                            src_vld_m2_o,
   output logic                            src_vld_m3_o,
   output logic [2:0]                      src_id_m1_o,
   output logic [2:0]                      src_id_m2_o,
   output logic [2:0]                      src_id_m3_o,
   output logic                            ld_stall_m0_o
);

   logic [TAG_SRC_NUM-1:0] elig;
   logic [TAG_SRC_NUM-1:0] gnt;
   logic                   win_vld;
   tag_src_e               win_id;
   logic                   hi_busy;
   logic [NUM_WAYS-1:0]    win_way;
   logic                   win_wr;
   logic                   stb_at_max;
   logic                   pf_at_max;

   logic [TAG_SRC_NUM-1:0] ack_m1_q;
   logic                   vld_m1_q, vld_m2_q, vld_m3_q;
   tag_src_e               id_m1_q, id_m2_q, id_m3_q;
   logic [TAG_SRC_NUM-1:0] req_pend_q;

   always_comb begin
      elig = req_m0_i;
      if (ecc_lock_i) begin
         elig = req_m0_i & (TAG_SRC_NUM'(1) << SRC_MAINT);
      end
      // MBIST ownership and reset both silence the arbiter outright.
      if (mbist_active_i || !csysreset_n) begin
         elig = '0;
      end
   end

   // Base order first, then aged STB/PF jump just below MAINT, then a forced
   // STB drain jumps to just below ALLOC.
   always_comb begin
      win_vld = 1'b0;
      win_id  = SRC_ALLOC;
      for (int i = TAG_SRC_NUM - 1; i >= 0; i--) begin
         if (elig[TAG_BASE_PRIO[i]]) begin
            win_vld = 1'b1;
            win_id  = TAG_BASE_PRIO[i];
         end
      end
      hi_busy = elig[SRC_ALLOC] | elig[SRC_EV] | elig[SRC_MAINT];
      if (!hi_busy) begin
         if (stb_at_max && elig[SRC_STB]) begin
            win_id = SRC_STB;
         end else if (pf_at_max && elig[SRC_PF]) begin
            win_id = SRC_PF;
         end
      end
      if (stb_force_i && elig[SRC_STB] && !elig[SRC_ALLOC]) begin
         win_id = SRC_STB;
      end
      gnt = '0;
      if (win_vld) begin
         gnt[win_id] = 1'b1;
      end
   end

   always_comb begin
      win_way = '0;
      win_wr  = 1'b0;
      for (int i = 0; i < TAG_SRC_NUM; i++) begin
         if (gnt[i]) begin
            win_way = way_m0_i[i*NUM_WAYS +: NUM_WAYS];
            win_wr  = wr_m0_i[i];
         end
      end
      if (gnt[SRC_LD] || gnt[SRC_PF]) begin
         win_wr = 1'b0;
      end
   end

   yamin_dcu_age_ctr #(.MAX(STARVE_MAX)) u_age_stb (
      .clk      (clk),
      .rst_n    (csysreset_n),
      .clr_i    (gnt[SRC_STB] | ~req_m0_i[SRC_STB]),
      .inc_i    (req_m0_i[SRC_STB] & ~gnt[SRC_STB]),
      .frz_i    (mbist_active_i),
      .at_max_o (stb_at_max)
   );

   yamin_dcu_age_ctr #(.MAX(STARVE_MAX)) u_age_pf (
      .clk      (clk),
      .rst_n    (csysreset_n),
      .clr_i    (gnt[SRC_PF] | ~req_m0_i[SRC_PF]),
      .inc_i    (req_m0_i[SRC_PF] & ~gnt[SRC_PF]),
      .frz_i    (mbist_active_i),
      .at_max_o (pf_at_max)
   );

   always_ff @(posedge clk or negedge csysreset_n) begin
      if (!csysreset_n) begin
         ack_m1_q   <= '0;
         vld_m1_q   <= 1'b0;
         vld_m2_q   <= 1'b0;
         vld_m3_q   <= 1'b0;
         id_m1_q    <= SRC_ALLOC;
         id_m2_q    <= SRC_ALLOC;
         id_m3_q    <= SRC_ALLOC;
         req_pend_q <= '0;
      end else begin
         ack_m1_q   <= gnt;
         vld_m1_q   <= win_vld;
         vld_m2_q   <= vld_m1_q;
         vld_m3_q   <= vld_m2_q;
         id_m1_q    <= win_vld ? win_id : SRC_ALLOC;
         id_m2_q    <= id_m1_q;
         id_m3_q    <= id_m2_q;
         req_pend_q <= req_m0_i & ~gnt;
      end
   end

   assign has_priority_m0_o = gnt;
   assign ram_tag_en_o      = !win_vld ? '0 :
                              (!win_wr && (win_way == '0)) ? '1 : win_way;
   assign ram_tag_wr_o      = win_vld & win_wr;
   assign ack_m1_o          = ack_m1_q;
   assign src_vld_m1_o      = vld_m1_q;
   assign src_vld_m2_o      = vld_m2_q;
   assign src_vld_m3_o      = vld_m3_q;
   assign src_id_m1_o       = id_m1_q;
   assign src_id_m2_o       = id_m2_q;
   assign src_id_m3_o       = id_m3_q;
   assign ld_stall_m0_o     = csysreset_n & req_m0_i[SRC_LD] & ~gnt[SRC_LD];

   a_grant_onehot: assert property (@(posedge clk) disable iff (!csysreset_n)
      $onehot0(has_priority_m0_o));

   // A requester that was denied must keep asking until it is granted.
   a_req_held: assert property (@(posedge clk) disable iff (!csysreset_n)
      (req_pend_q & ~req_m0_i) == '0);

   a_no_x: assert property (@(posedge clk) disable iff (!csysreset_n)
      !$isunknown({has_priority_m0_o, ack_m1_o, ram_tag_en_o, ram_tag_wr_o,
                   src_vld_m1_o, src_vld_m2_o, src_vld_m3_o, src_id_m1_o,
                   src_id_m2_o, src_id_m3_o, ld_stall_m0_o}));

endmodule

// File: tb/tb_yamin_dcu_tag_arb.sv
// Directed bench for the tag RAM arbiter: a rank-based reference model is
// compared every cycle, with literal checks pinning the key scenarios.
module tb_yamin_dcu_tag_arb;

   localparam int NW = 4;
   localparam int SM = 7;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [5:0]    req, wr;
   logic [6*NW-1:0] way;
   logic          ecc_lock, mbist, stb_force;
   logic [5:0]    hp, ack;
   logic [NW-1:0] en;
   logic          wr_o, v1, v2, v3, stall;
   logic [2:0]    id1, id2, id3;

   int n_tests = 0;
   int n_fail  = 0;

   logic [5:0] hold_mask;
   logic [5:0] gnt_seen;
   int age_stb, age_pf;
   logic pv1, pv2, pv3;
   int pid1, pid2, pid3;
   logic [5:0] pack;
   int ids[$];
   int first;

   yamin_dcu_tag_arb dut (
      .clk               (clk),
      .csysreset_n       (rst_n),
      .req_m0_i          (req),
      .wr_m0_i           (wr),
      .way_m0_i          (way),
      .ecc_lock_i        (ecc_lock),
      .mbist_active_i    (mbist),
      .stb_force_i       (stb_force),
      .has_priority_m0_o (hp),
      .ack_m1_o          (ack),
      .ram_tag_en_o      (en),
      .ram_tag_wr_o      (wr_o),
      .src_vld_m1_o      (v1),
      .src_vld_m2_o      (v2),
      .src_vld_m3_o      (v3),
      .src_id_m1_o       (id1),
      .src_id_m2_o       (id2),
      .src_id_m3_o       (id3),
      .ld_stall_m0_o     (stall)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Lower rank wins; promotions just move a source's rank.
   function automatic int model_winner(logic [5:0] r, logic lock, logic mb,
                                       logic frc, int a_stb, int a_pf);
      int rank [6];
      int best, best_rank;
      rank = '{10, 20, 30, 50, 60, 70};
      if (a_stb == SM) rank[4] = 40;
      if (a_pf == SM)  rank[5] = 45;
      if (frc)         rank[4] = 15;
      best = -1;
      best_rank = 1000;
      if (mb) return -1;
      for (int i = 0; i < 6; i++) begin
         if (r[i] && (!lock || i == 2) && rank[i] < best_rank) begin
            best = i;
            best_rank = rank[i];
         end
      end
      return best;
   endfunction

   always @(negedge clk) begin
      int w;
      logic [5:0] eg;
      logic [NW-1:0] wy, ee;
      logic ewr;
      if (!rst_n) begin
         age_stb = 0; age_pf = 0;
         pv1 = 0; pv2 = 0; pv3 = 0; pid1 = 0; pid2 = 0; pid3 = 0;
         pack = '0; gnt_seen = '0;
         chk("reset_outputs", {hp, ack, en, wr_o, v1, v2, v3, stall}, 0);
      end else begin
         w = model_winner(req, ecc_lock, mbist, stb_force, age_stb, age_pf);
         eg = '0; ee = '0; ewr = 1'b0; wy = '0;
         if (w >= 0) begin
            eg[w] = 1'b1;
            wy  = way[w*NW +: NW];
            ewr = wr[w] && (w != 3) && (w != 5);
            ee  = (!ewr && wy == '0) ? '1 : wy;
         end
         chk("has_priority", hp, eg);
         chk("ram_tag_en", en, ee);
         chk("ram_tag_wr", wr_o, ewr);
         chk("ld_stall", stall, req[3] && !eg[3]);
         chk("ack_m1", ack, pack);
         chk("src_vld", {v1, v2, v3}, {pv1, pv2, pv3});
         if (pv1) chk("src_id_m1", id1, pid1);
         if (pv2) chk("src_id_m2", id2, pid2);
         if (pv3) chk("src_id_m3", id3, pid3);
         if (!mbist) begin
            age_stb = (req[4] && !eg[4]) ? ((age_stb < SM) ? age_stb + 1 : SM) : 0;
            age_pf  = (req[5] && !eg[5]) ? ((age_pf  < SM) ? age_pf  + 1 : SM) : 0;
         end
         pv3 = pv2; pid3 = pid2;
         pv2 = pv1; pid2 = pid1;
         pv1 = (w >= 0); pid1 = (w >= 0) ? w : 0;
         pack = eg;
         gnt_seen = hp;
      end
   end

   // Granted requesters drop their request unless told to keep re-asking.
   task automatic step();
      @(posedge clk);
      #1;
      req = req & ~(gnt_seen & ~hold_mask);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (req != 0 && n < 50) begin
         step();
         n++;
      end
      chk("drain_done", req, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req = '0; wr = '0; way = '0;
      ecc_lock = 1'b0; mbist = 1'b0; stb_force = 1'b0; hold_mask = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // All six requesters at once: strict base order, one per cycle.
      req = 6'h3F;
      #3 chk("t1_first_grant", hp, 6'h01);
      for (int c = 0; c < 9; c++) begin
         step();
         #3;
         if (c == 0) chk("t1_ack_m1", ack, 6'h01);
         if (v3) ids.push_back(int'(id3));
      end
      chk("t1_m3_count", ids.size(), 6);
      for (int i = 0; i < ids.size() && i < 6; i++) chk("t1_m3_seq", ids[i], i);

      // LD hogging: STB waits 7 cycles, wins the 8th; repeat shows counter cleared.
      step();
      hold_mask = 6'h08;
      req = 6'h18;
      for (int pass = 0; pass < 2; pass++) begin
         first = 0;
         for (int c = 1; c <= 12; c++) begin
            #3;
            if (hp[4] && first == 0) first = c;
            step();
         end
         chk("t2_stb_grant_cycle", first, 8);
         req = req | 6'h10;
      end
      req = req & ~6'h10;
      hold_mask = '0;
      drain();

      // ECC lock: only MAINT may win, LD stalls until the lock drops.
      ecc_lock = 1'b1;
      req = 6'h0C;
      #3 chk("t3_maint_only", hp, 6'h04);
      chk("t3_ld_stall", stall, 1);
      for (int c = 0; c < 2; c++) begin
         step();
         #3 chk("t3_locked_none", hp, 0);
         chk("t3_ld_stall_held", stall, 1);
      end
      step();
      ecc_lock = 1'b0;
      #3 chk("t3_ld_after_lock", hp, 6'h08);
      step();
      // Aging keeps counting under the lock; aged STB beats LD on release.
      ecc_lock = 1'b1;
      req = 6'h1C;
      for (int c = 0; c < 8; c++) begin
         #3;
         step();
      end
      ecc_lock = 1'b0;
      #3 chk("t3_aged_stb_first", hp, 6'h10);
      step();
      #3 chk("t3_ld_next", hp, 6'h08);
      drain();

      // MBIST freezes STB's age at 3; it then needs 4 more denials.
      hold_mask = 6'h08;
      req = 6'h18;
      for (int c = 0; c < 3; c++) begin
         #3 chk("t4_ld_grant", hp, 6'h08);
         step();
      end
      mbist = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #3 chk("t4_mbist_no_grant", hp, 0);
         chk("t4_mbist_no_en", en, 0);
         step();
      end
      mbist = 1'b0;
      first = 0;
      for (int c = 1; c <= 10; c++) begin
         #3;
         if (hp[4] && first == 0) first = c;
         step();
      end
      chk("t4_stb_after_mbist", first, 5);
      hold_mask = '0;
      drain();

      // Tag RAM strobes.
      wr = 6'h10;
      way[4*NW +: NW] = 4'b0100;
      req = 6'h10;
      #3 chk("t5_stb_en", en, 4'b0100);
      chk("t5_stb_wr", wr_o, 1);
      step();
      wr = 6'h30;
      req = 6'h20;
      #3 chk("t5_pf_en", en, 4'b1111);
      chk("t5_pf_wr", wr_o, 0);
      step();
      wr = 6'h08;
      way[3*NW +: NW] = 4'b0010;
      req = 6'h08;
      #3 chk("t5_ld_en", en, 4'b0010);
      chk("t5_ld_wr", wr_o, 0);
      step();
      wr = '0;
      way = '0;
      drain();

      // Stream forced STB ahead of EV.
      stb_force = 1'b1;
      req = 6'h12;
      #3 chk("t5_force_stb", hp, 6'h10);
      step();
      stb_force = 1'b0;
      drain();

      // Async reset while M2 is valid flushes the pipeline.
      req = 6'h3F;
      step();
      step();
      #1 chk("t6_m2_valid", v2, 1);
      rst_n = 1'b0;
      #1 chk("t6_flush", {ack, v1, v2, v3}, 0);
      chk("t6_no_grant", hp, 0);
      req = '0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         #3 chk("t6_no_residual", {ack, v1, v2, v3}, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
